pipelined_addsub: RTL and testbench

//  Parametrised, pipelined N-bit add/subtract unit; sequential successor of the combinational N-bit adder.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_slice.sv | 14 +
 rtl/pipelined_addsub.sv | 103 ++++++++++
 tb/tb_pipelined_addsub.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// The mode encoding doubles as the carry-in of the lowest slice.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Subtraction runs as a + ~b + 1, so the borrow is the inverted carry-out.
    function automatic logic top_bit(input logic md, input logic co);
        return (md == MODE_SUB) ? ~co : co;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the carry chain; purely combinational.
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined W-bit add/subtract: one CHUNK-bit carry slice resolved per stage,
// in-order results after STAGES cycles, one operation accepted per cycle.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W:0]   sum
);

    localparam int STAGES = W / CHUNK;

    if (W < 1 || CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_param_chk
        $error("pipelined_addsub: need W >= 1, 1 <= CHUNK <= W and W %% CHUNK == 0");
    end

    logic [STAGES:1]              vld_q, vld_d;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES-1:0][W-1:0]     acc_r, bp_r;
    logic [STAGES-1:0]            cy_r, md_r;

    assign vld_pipe = {vld_q, in_valid};

    always_comb vld_d = vld_pipe[STAGES-1:0];

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [W-1:0]     in_acc, in_bp;
        logic             in_cy, in_md;
        logic [W-1:0]     acc_d, acc_q, bp_d, bp_q;
        logic             cy_d, cy_q, md_d, md_q;
        logic [CHUNK-1:0] s;
        logic             co;

        // acc carries finished low result slices plus still-raw upper slices of A.
        if (gi == 0) begin : g_first
            assign in_acc = a;
            assign in_bp  = (mode == MODE_SUB) ? ~b : b;
            assign in_cy  = mode;
            assign in_md  = mode;
        end else begin : g_next
            assign in_acc = acc_r[gi-1];
            assign in_bp  = bp_r[gi-1];
            assign in_cy  = cy_r[gi-1];
            assign in_md  = md_r[gi-1];
        end

        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .x  (in_acc[gi*CHUNK +: CHUNK]),
            .y  (in_bp[gi*CHUNK +: CHUNK]),
            .ci (in_cy),
            .s  (s),
            .co (co)
        );

        always_comb begin
            acc_d                      = in_acc;
            acc_d[gi*CHUNK +: CHUNK]   = s;
            bp_d                       = in_bp;
            cy_d                       = co;
            md_d                       = in_md;
        end

        // Data only moves with a valid op, so bubbles leave the last result in place.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                bp_q  <= '0;
                cy_q  <= 1'b0;
                md_q  <= 1'b0;
            end else if (vld_pipe[gi]) begin
                acc_q <= acc_d;
                bp_q  <= bp_d;
                cy_q  <= cy_d;
                md_q  <= md_d;
            end
        end

        assign acc_r[gi] = acc_q;
        assign bp_r[gi]  = bp_q;
        assign cy_r[gi]  = cy_q;
        assign md_r[gi]  = md_q;
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = {top_bit(md_r[STAGES-1], cy_r[STAGES-1]), acc_r[STAGES-1]};

    logic unused_bp;
    assign unused_bp = ^bp_r[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: three builds (8/4, 1/1, 8/8) share one stimulus stream,
// each with its own expected-result queue drained by a negedge monitor.
module tb_pipelined_addsub;

    typedef struct {
        logic [8:0] val;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       mode;
    logic [7:0] a, b;

    logic       ov0, ov1, ov2;
    logic [8:0] sum0, sum2;
    logic [1:0] sum1;

    logic       ov[3];
    logic [8:0] sv[3];
    logic [8:0] last[3];
    exp_t       sb[3][$];
    int         lat[3] = '{2, 1, 1};

    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub #(.W(8), .CHUNK(4)) u_dut84 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .out_valid(ov0), .sum(sum0)
    );

    pipelined_addsub #(.W(1), .CHUNK(1)) u_dut11 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a[0:0]), .b(b[0:0]), .out_valid(ov1), .sum(sum1)
    );

    pipelined_addsub #(.W(8), .CHUNK(8)) u_dut88 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .out_valid(ov2), .sum(sum2)
    );

    assign ov[0] = ov0;
    assign ov[1] = ov1;
    assign ov[2] = ov2;
    assign sv[0] = sum0;
    assign sv[1] = {7'b0, sum1};
    assign sv[2] = sum2;

    function automatic logic [8:0] model(input int w, input logic m,
                                         input logic [7:0] x, input logic [7:0] y);
        int xi, yi, r;
        xi = int'(x) & ((1 << w) - 1);
        yi = int'(y) & ((1 << w) - 1);
        r  = m ? (xi - yi) : (xi + yi);
        return 9'(r & ((1 << (w + 1)) - 1));
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            last[k] = '0;
        end
    endtask

    task automatic issue(input logic m, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [8:0] hand, input bit use_hand);
        exp_t e;
        in_valid = 1'b1;
        mode = m;
        a = ia;
        b = ib;
        e.val = use_hand ? hand : model(8, m, ia, ib);
        e.due = cyc + lat[0];
        sb[0].push_back(e);
        e.val = model(1, m, ia, ib);
        e.due = cyc + lat[1];
        sb[1].push_back(e);
        e.val = model(8, m, ia, ib);
        e.due = cyc + lat[2];
        sb[2].push_back(e);
        tick();
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        mode = 1'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        tick();
    endtask

    // Monitor: every valid output must match the queue head on its due cycle;
    // idle cycles must hold the previous result and must not be owed an output.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("unexpected_valid[%0d]", k), 9'(ov[k]), 9'd0);
                    end else begin
                        exp_t e;
                        e = sb[k].pop_front();
                        chk($sformatf("result[%0d]", k), sv[k], e.val);
                        chk($sformatf("latency[%0d]", k), 9'(cyc - e.due), 9'd0);
                    end
                    last[k] = sv[k];
                end else begin
                    chk($sformatf("hold[%0d]", k), sv[k], last[k]);
                    if (sb[k].size() != 0 && sb[k][0].due <= cyc)
                        chk($sformatf("missing_valid[%0d]", k), 9'(ov[k]), 9'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with in_valid high: nothing may be accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        mode = 1'b0;
        a = 8'hFF;
        b = 8'h01;
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_valid[%0d]", k), 9'(ov[k]), 9'd0);
                chk($sformatf("rst_sum[%0d]", k), sv[k], 9'd0);
            end
        end
        flush();
        mon_en = 1'b1;
        rst = 1'b0;
        in_valid = 1'b0;
        bubble();
        bubble();

        issue(1'b0, 8'hFF, 8'h01, 9'h100, 1'b1);
        bubble();
        bubble();
        bubble();
        issue(1'b1, 8'h05, 8'h07, 9'h1FE, 1'b1);
        issue(1'b1, 8'h07, 8'h05, 9'h002, 1'b1);
        issue(1'b0, 8'h00, 8'h00, 9'h000, 1'b1);
        issue(1'b1, 8'h00, 8'hFF, 9'h101, 1'b1);
        issue(1'b0, 8'h0F, 8'h01, 9'h010, 1'b1);
        bubble();

        // Every 1-bit combination, both modes.
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 2; x++)
                for (int y = 0; y < 2; y++)
                    issue(1'(m), 8'(x), 8'(y), 9'd0, 1'b0);
        bubble();

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            issue(1'($urandom), 8'($urandom), 8'($urandom), 9'd0, 1'b0);
        end
        repeat (3) bubble();

        // Reset one cycle after an accept: the 2-stage build must drop it.
        issue(1'b0, 8'h12, 8'h34, 9'h046, 1'b1);
        rst = 1'b1;
        in_valid = 1'b1;
        mode = 1'b1;
        a = 8'h55;
        b = 8'h11;
        tick();
        flush();
        rst = 1'b0;
        repeat (4) bubble();

        issue(1'b0, 8'h80, 8'h80, 9'h100, 1'b1);
        repeat (4) bubble();

        for (int k = 0; k < 3; k++)
            chk($sformatf("drained[%0d]", k), 9'(sb[k].size()), 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
